// File: rtl/rd_stream_fwft.sv
`timescale 1ns/1ps
// Converts a request / registered-RAM FIFO read port into a first-word-fall-through
// valid/ready stream, buffering up to two words in a head register and a skid register.
module rd_stream_fwft #(
    parameter int DWIDTH = 8
) (
    input  logic              rd_clk_i,
    input  logic              aclr_i,
    input  logic              fifo_empty_i,
    input  logic [DWIDTH-1:0] fifo_q_i,
    output logic              fifo_rd_req_o,
    output logic [DWIDTH-1:0] m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [1:0]        m_level_o,
    output logic              ovf_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } level_t;

    level_t            level;
    logic              inflight;
    logic [DWIDTH-1:0] head;
    logic [DWIDTH-1:0] skid;
    logic              ovf;
    logic              pop;
    logic [2:0]        occupancy;

    assign m_valid_o = (level != EMPTY);
    assign pop       = m_valid_o & m_ready_i;

    // A pop implies level >= 1, so the subtraction can never wrap below zero.
    assign occupancy     = {1'b0, level} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rd_req_o = aclr_i & ~fifo_empty_i & (occupancy < 3'd2);

    assign m_data_o  = head;
    assign m_level_o = level;
    assign ovf_o     = ovf;

    always_ff @(posedge rd_clk_i or negedge aclr_i) begin
        if (!aclr_i) begin
            // NOTE: head/skid are plain registers, not a memory array, so they can take the async clear cheaply.
            level    <= EMPTY;
            inflight <= 1'b0;
            head     <= '0;
            skid     <= '0;
            ovf      <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every branch sees the pre-edge level/head/skid.
            inflight <= fifo_rd_req_o;
            case (level)
                EMPTY: begin
                    if (inflight) begin
                        level <= ONE;
                        head  <= fifo_q_i;
                    end
                end
                ONE: begin
                    if (inflight && pop) begin
                        head <= fifo_q_i;
                    end else if (inflight) begin
                        level <= TWO;
                        skid  <= fifo_q_i;
                    end else if (pop) begin
                        level <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head <= skid;
                        if (inflight) begin
                            skid <= fifo_q_i;
                        end else begin
                            level <= ONE;
                        end
                    end else if (inflight) begin
                        // No free slot: drop the word and flag it until reset.
                        ovf <= 1'b1;
                    end
                end
                default: level <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_rd_stream_fwft.sv
`timescale 1ns/1ps
// Scoreboard bench for rd_stream_fwft: a FIFO model feeds words, expected words are
// queued at stimulus time and a negedge monitor pops and compares every accepted word.
module tb_rd_stream_fwft;

    localparam int            DW   = 8;
    localparam logic [DW-1:0] JUNK = 8'hEE;

    logic          rd_clk_i     = 1'b0;
    logic          aclr_i       = 1'b0;
    logic          fifo_empty_i = 1'b1;
    logic [DW-1:0] fifo_q_i     = JUNK;
    logic          fifo_rd_req_o;
    logic [DW-1:0] m_data_o;
    logic          m_valid_o;
    logic          m_ready_i    = 1'b0;
    logic [1:0]    m_level_o;
    logic          ovf_o;

    logic          hold_empty   = 1'b0;
    logic [DW-1:0] src[$];
    logic [DW-1:0] exp_q[$];
    int            n_checks     = 0;
    int            n_pass       = 0;

    rd_stream_fwft #(.DWIDTH(DW)) dut (
        .rd_clk_i      (rd_clk_i),
        .aclr_i        (aclr_i),
        .fifo_empty_i  (fifo_empty_i),
        .fifo_q_i      (fifo_q_i),
        .fifo_rd_req_o (fifo_rd_req_o),
        .m_data_o      (m_data_o),
        .m_valid_o     (m_valid_o),
        .m_ready_i     (m_ready_i),
        .m_level_o     (m_level_o),
        .ovf_o         (ovf_o)
    );

    always #5 rd_clk_i = ~rd_clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic step();
        @(posedge rd_clk_i);
        #1;
    endtask

    task automatic at_neg();
        @(negedge rd_clk_i);
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        src.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
        check(name, exp_q.size(), 0);
    endtask

    // FIFO model: registered RAM read, data valid the cycle after the request.
    logic req_s;
    always begin
        @(negedge rd_clk_i);
        req_s = fifo_rd_req_o;
        @(posedge rd_clk_i);
        #2;
        if (req_s && src.size() != 0) fifo_q_i = src.pop_front();
        else fifo_q_i = JUNK;
        fifo_empty_i = hold_empty || (src.size() == 0);
    end

    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    always @(negedge rd_clk_i) begin
        check("level_max", m_level_o <= 2'd2, 1);
        check("valid_vs_level", m_valid_o, m_level_o != 2'd0);
        if (prev_stall && m_valid_o) check("hold_data", m_data_o, prev_data);
        if (m_valid_o && m_ready_i) begin
            check("pop_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("stream_data", m_data_o, exp_q.pop_front());
        end
        prev_stall = m_valid_o && !m_ready_i;
        prev_data  = m_data_o;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int reqs;

        // Reset state, and no request while held in reset even with data available.
        m_ready_i = 1'b1;
        repeat (2) step();
        check("rst_valid", m_valid_o, 0);
        check("rst_level", m_level_o, 0);
        check("rst_data", m_data_o, 0);
        check("rst_ovf", ovf_o, 0);
        push_word(8'h11);
        repeat (2) step();
        at_neg();
        check("rst_empty_low", fifo_empty_i, 0);
        check("rst_no_req", fifo_rd_req_o, 0);
        step();
        aclr_i = 1'b1;
        drain("rst_release_word", 10);
        repeat (3) step();

        // Single word: request at N, valid at N+2, single request pulse.
        push_word(8'hA5);
        at_neg();
        check("sw_req_n", fifo_rd_req_o, 1);
        check("sw_valid_n", m_valid_o, 0);
        step(); at_neg();
        check("sw_req_n1", fifo_rd_req_o, 0);
        check("sw_valid_n1", m_valid_o, 0);
        step(); at_neg();
        check("sw_req_n2", fifo_rd_req_o, 0);
        check("sw_valid_n2", m_valid_o, 1);
        check("sw_data_n2", m_data_o, 8'hA5);
        step(); at_neg();
        check("sw_req_n3", fifo_rd_req_o, 0);
        check("sw_valid_n3", m_valid_o, 0);
        check("sw_level_n3", m_level_o, 0);
        repeat (2) step();

        // Streaming 16 words: no bubbles once the first word appears.
        for (int i = 0; i < 16; i++) push_word(8'(i));
        at_neg();
        for (int c = 0; c < 10 && !m_valid_o; c++) begin
            step(); at_neg();
        end
        check("stream_start", m_valid_o, 1);
        for (int i = 1; i < 16; i++) begin
            step(); at_neg();
            check("stream_no_bubble", m_valid_o, 1);
        end
        step(); at_neg();
        check("stream_end", m_valid_o, 0);
        check("stream_all", exp_q.size(), 0);
        repeat (2) step();

        // Backpressure: exactly two requests, buffer full, head held.
        m_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) push_word(8'h20 + 8'(i));
        reqs = 0;
        for (int i = 0; i < 6; i++) begin
            at_neg();
            reqs += int'(fifo_rd_req_o);
            step();
        end
        at_neg();
        check("bp_req_count", reqs, 2);
        check("bp_level", m_level_o, 2);
        check("bp_head", m_data_o, 8'h20);
        step();
        m_ready_i = 1'b1;
        drain("bp_drain", 30);
        repeat (3) step();

        // Random ready / empty toggling over 1000 words.
        for (int i = 0; i < 1000; i++) push_word(8'(i * 7 + 3));
        for (int c = 0; c < 20000 && exp_q.size() != 0; c++) begin
            m_ready_i  = 1'($urandom_range(0, 1));
            hold_empty = ($urandom_range(0, 3) == 0);
            step();
        end
        hold_empty = 1'b0;
        m_ready_i  = 1'b1;
        drain("rand_drain", 20);
        check("rand_ovf", ovf_o, 0);
        repeat (3) step();

        // Reset with a full buffer: outputs clear at once, nothing appears after release.
        m_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) push_word(8'h40 + 8'(i));
        repeat (5) step();
        at_neg();
        check("mr_level_full", m_level_o, 2);
        step();
        aclr_i = 1'b0;
        src.delete();
        exp_q.delete();
        #1;
        check("mr_valid", m_valid_o, 0);
        check("mr_level", m_level_o, 0);
        check("mr_data", m_data_o, 0);
        step();
        step();
        aclr_i    = 1'b1;
        m_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            check("mr_no_spurious", m_valid_o, 0);
            step();
        end

        // Forced arrival at level 2 without a pop: dropped, sticky overflow.
        m_ready_i = 1'b0;
        push_word(8'h30);
        push_word(8'h31);
        repeat (5) step();
        at_neg();
        check("ovf_level_full", m_level_o, 2);
        force dut.inflight = 1'b1;
        step();
        release dut.inflight;
        at_neg();
        check("ovf_set", ovf_o, 1);
        check("ovf_level_hold", m_level_o, 2);
        check("ovf_head_hold", m_data_o, 8'h30);
        repeat (3) step();
        at_neg();
        check("ovf_sticky", ovf_o, 1);
        step();
        m_ready_i = 1'b1;
        drain("ovf_drain", 10);
        step(); at_neg();
        check("ovf_after_drain", ovf_o, 1);
        check("ovf_empty_after_drain", m_valid_o, 0);
        step();
        aclr_i = 1'b0;
        #1;
        check("ovf_cleared", ovf_o, 0);
        step();
        aclr_i = 1'b1;
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
